// File: rtl/integer_exp_sequencer.sv
// Integer-only exponential sequencer (I-BERT i-exp) for the softmax path.
// Clamps q to <= 0, splits it as q = -z*q_ln2 + p with a bit-serial divider,
// requests poly(p) from integer_polynomial, then shifts the result right by z.
module integer_exp_sequencer #(
  parameter int Q_W    = 32,
  parameter int S_W    = 16,
  parameter int COEF_A = 92,
  parameter int COEF_B = 346,
  parameter int COEF_C = 88
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] in_q,
  input  logic [S_W-1:0] in_S,
  input  logic [Q_W-1:0] in_q_ln2,
  output logic           poly_start,
  output logic [Q_W-1:0] poly_q,
  output logic [S_W-1:0] poly_S,
  output logic [Q_W-1:0] poly_a,
  output logic [Q_W-1:0] poly_b,
  output logic [Q_W-1:0] poly_c,
  input  logic           poly_done,
  input  logic [Q_W-1:0] poly_q_out,
  input  logic [S_W-1:0] poly_S_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] out_q,
  output logic [S_W-1:0] out_S,
  output logic           out_err
);

  localparam int CNT_W = $clog2(Q_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_W - 1);
  localparam logic [Q_W-1:0]   Z_SAT    = Q_W'(Q_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic [Q_W-1:0]   qc_r;    // clamped operand, always <= 0
  logic [Q_W-1:0]   ln2_r;   // divisor q_ln2 (known > 0 once in DIV)
  logic [Q_W-1:0]   dvd_r;   // dividend bits still to be shifted in
  logic [Q_W-1:0]   rem_r;   // partial remainder, always < divisor
  logic [Q_W-1:0]   z_r;     // quotient z, built MSB first
  logic [CNT_W-1:0] cnt_r;

  logic [Q_W-1:0] q_clamp;
  logic [Q_W-1:0] q_mag;
  logic           ln2_bad;
  logic [Q_W:0]   trial;
  logic [Q_W:0]   diff;
  logic           fits;
  logic [Q_W-1:0] z_step;
  logic [Q_W-1:0] p_final;
  logic [Q_W-1:0] shifted;

  assign poly_a = Q_W'(COEF_A);
  assign poly_b = Q_W'(COEF_B);
  assign poly_c = Q_W'(COEF_C);

  assign in_ready   = (state == S_IDLE);
  assign poly_start = (state == S_REQ);
  assign out_valid  = (state == S_OUT);

  // Operand preparation, one divider step and the final shift, all combinational.
  always_comb begin
    q_clamp = ($signed(in_q) > 0) ? '0 : in_q;
    // qc <= 0, so |qc| = -qc; the unsigned Q_W-bit view also covers qc = -2^(Q_W-1).
    q_mag   = '0 - q_clamp;
    ln2_bad = ($signed(in_q_ln2) <= 0);

    trial   = {rem_r, dvd_r[Q_W-1]};
    diff    = trial - {1'b0, ln2_r};
    fits    = ~diff[Q_W];              // no borrow: trial >= divisor
    z_step  = {z_r[Q_W-2:0], fits};
    // Product deliberately truncated to Q_W bits; result lies in (-q_ln2, 0].
    p_final = qc_r + z_step * ln2_r;

    shifted = (z_r >= Z_SAT) ? '0
                             : Q_W'($signed(poly_q_out) >>> z_r[CNT_W-1:0]);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and infers a latch.
    state_next = state;
    unique case (state)
      S_IDLE: if (in_valid) state_next = ln2_bad ? S_OUT : S_DIV;
      S_DIV:  if (cnt_r == CNT_LAST) state_next = S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: if (poly_done) state_next = S_OUT;
      S_OUT:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, serial divide, request operands and result capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: working registers are reset too so outputs and the divider never
    // carry X into a transaction after reset; cost is small at this width.
    if (rst) begin
      qc_r    <= '0;
      ln2_r   <= '0;
      dvd_r   <= '0;
      rem_r   <= '0;
      z_r     <= '0;
      cnt_r   <= '0;
      poly_q  <= '0;
      poly_S  <= '0;
      out_q   <= '0;
      out_S   <= '0;
      out_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            qc_r   <= q_clamp;
            ln2_r  <= in_q_ln2;
            dvd_r  <= q_mag;
            rem_r  <= '0;
            z_r    <= '0;
            cnt_r  <= '0;
            poly_S <= in_S;
            if (ln2_bad) begin
              out_q   <= '0;
              out_S   <= '0;
              out_err <= 1'b1;
            end
          end
        end
        S_DIV: begin
          dvd_r <= {dvd_r[Q_W-2:0], 1'b0};
          rem_r <= fits ? diff[Q_W-1:0] : trial[Q_W-1:0];
          z_r   <= z_step;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) poly_q <= p_final;
        end
        S_WAIT: begin
          if (poly_done) begin
            out_q   <= shifted;
            out_S   <= poly_S_out;
            out_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_integer_exp_sequencer.sv
// Bench for integer_exp_sequencer: directed vectors, polynomial stub,
// scoreboard queues popped by independent monitor processes.
module tb_integer_exp_sequencer;

  localparam int Q_W = 32;
  localparam int S_W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [Q_W-1:0] in_q;
  logic [S_W-1:0] in_S;
  logic [Q_W-1:0] in_q_ln2;
  logic           poly_start;
  logic [Q_W-1:0] poly_q;
  logic [S_W-1:0] poly_S;
  logic [Q_W-1:0] poly_a, poly_b, poly_c;
  logic           poly_done;
  logic [Q_W-1:0] poly_q_out;
  logic [S_W-1:0] poly_S_out;
  logic           out_valid;
  logic           out_ready;
  logic [Q_W-1:0] out_q;
  logic [S_W-1:0] out_S;
  logic           out_err;

  integer_exp_sequencer #(.Q_W(Q_W), .S_W(S_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_q(in_q), .in_S(in_S), .in_q_ln2(in_q_ln2),
    .poly_start(poly_start), .poly_q(poly_q), .poly_S(poly_S),
    .poly_a(poly_a), .poly_b(poly_b), .poly_c(poly_c),
    .poly_done(poly_done), .poly_q_out(poly_q_out), .poly_S_out(poly_S_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_S(out_S), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [Q_W-1:0] q;
    logic [S_W-1:0] s;
    logic           err;
  } out_exp_t;

  typedef struct {
    logic [Q_W-1:0] q;
    logic [S_W-1:0] s;
  } poly_exp_t;

  out_exp_t  sb_out[$];
  poly_exp_t sb_poly[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_out(input logic [Q_W-1:0] q, input logic [S_W-1:0] s, input logic err);
    out_exp_t e;
    e.q = q; e.s = s; e.err = err;
    sb_out.push_back(e);
  endtask

  task automatic push_poly(input logic [Q_W-1:0] q, input logic [S_W-1:0] s);
    poly_exp_t e;
    e.q = q; e.s = s;
    sb_poly.push_back(e);
  endtask

  // Polynomial stub: checks the request, answers 3 cycles after poly_start.
  int             last_start_cyc = 0;
  int             done_len = 1;
  logic [Q_W-1:0] stub_pq;
  logic [S_W-1:0] stub_ps;
  poly_exp_t      stub_e;
  initial begin
    poly_done  = 1'b0;
    poly_q_out = '0;
    poly_S_out = '0;
    forever begin
      @(negedge clk);
      if (!rst && poly_start) begin
        last_start_cyc = cyc;
        stub_pq = poly_q;
        stub_ps = poly_S;
        if (sb_poly.size() == 0) begin
          n_checks++;
          $display("FAIL poly_unexpected: poly_start with poly_q=%0h, none expected", stub_pq);
        end else begin
          stub_e = sb_poly.pop_front();
          check("poly_q", stub_pq, stub_e.q);
          check("poly_S", stub_ps, stub_e.s);
        end
        @(negedge clk);
        check("poly_start_width", poly_start, 1'b0);
        repeat (2) @(negedge clk);
        poly_done  = 1'b1;
        poly_q_out = 32'd4096 + stub_pq;
        poly_S_out = stub_ps << 1;
        repeat (done_len) @(negedge clk);
        poly_done  = 1'b0;
      end
    end
  end

  // Output monitor: one pop per accepted result.
  out_exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_out.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: out_q=%0h out_S=%0h out_err=%0b", out_q, out_S, out_err);
        end else begin
          mon_e = sb_out.pop_front();
          check("out_q", out_q, mon_e.q);
          check("out_S", out_S, mon_e.s);
          check("out_err", out_err, mon_e.err);
        end
      end
    end
  end

  task automatic send(input logic [Q_W-1:0] q, input logic [S_W-1:0] s,
                      input logic [Q_W-1:0] l, output int n0);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("send_ready_timeout", in_ready, 1'b1);
    in_q = q; in_S = s; in_q_ln2 = l; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb_out.size() != 0 || sb_poly.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_out", sb_out.size(), 0);
    check("drain_poly", sb_poly.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},   in_ready,   1'b1);
    check({tag, "_poly_start"}, poly_start, 1'b0);
    check({tag, "_out_valid"},  out_valid,  1'b0);
    check({tag, "_out_q"},      out_q,      '0);
    check({tag, "_out_S"},      out_S,      '0);
    check({tag, "_out_err"},    out_err,    1'b0);
    check({tag, "_poly_q"},     poly_q,     '0);
    check({tag, "_poly_S"},     poly_S,     '0);
  endtask

  int n0;
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_q = '0; in_S = '0; in_q_ln2 = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst");
    check("coef_a", poly_a, 32'd92);
    check("coef_b", poly_b, 32'd346);
    check("coef_c", poly_c, 32'd88);
    rst = 1'b0;

    // T1: z=3, p=-10, poly 4086 >>> 3 = 510; start in cycle T+33.
    push_poly(-32'sd10, 16'd16);
    push_out(32'd510, 16'd32, 1'b0);
    send(-32'sd100, 16'd16, 32'd30, n0);
    drain();
    check("t1_start_latency", last_start_cyc - n0, 32);

    // T2: z=0 cases; poly_done held 3 cycles on the second one.
    push_poly(-32'sd29, 16'd5);
    push_out(32'd4067, 16'd10, 1'b0);
    send(-32'sd29, 16'd5, 32'd30, n0);
    drain();
    done_len = 3;
    push_poly(32'd0, 16'd7);
    push_out(32'd4096, 16'd14, 1'b0);
    send(32'd50, 16'd7, 32'd30, n0);
    drain();
    done_len = 1;

    // T3: large z saturates to 0 but still issues the request.
    push_poly(32'd0, 16'd9);
    push_out(32'd0, 16'd18, 1'b0);
    send(-32'sd3000, 16'd9, 32'd30, n0);
    drain();
    push_poly(32'd0, 16'd3);
    push_out(32'd0, 16'd6, 1'b0);
    send(32'h8000_0000, 16'd3, 32'd1, n0);
    drain();

    // T4: q_ln2 <= 0 -> error result in T+1, no request.
    push_out(32'd0, 16'd0, 1'b1);
    send(-32'sd100, 16'd16, 32'd0, n0);
    check("t4_err_latency", out_valid, 1'b1);
    drain();
    push_out(32'd0, 16'd0, 1'b1);
    send(-32'sd100, 16'd16, -32'sd5, n0);
    check("t4_neg_ln2_latency", out_valid, 1'b1);
    drain();

    // T5: back-pressure for 5 cycles.
    @(posedge clk); #1 out_ready = 1'b0;
    push_poly(-32'sd10, 16'd16);
    push_out(32'd510, 16'd32, 1'b0);
    send(-32'sd100, 16'd16, 32'd30, n0);
    for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
    check("t5_valid_seen", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_q = -32'sd7; in_S = 16'd1; in_q_ln2 = 32'd1; in_valid = 1'b1;
      check("t5_hold_valid", out_valid, 1'b1);
      check("t5_hold_q",     out_q,     32'd510);
      check("t5_hold_S",     out_S,     16'd32);
      check("t5_in_ready",   in_ready,  1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_idle_ready", in_ready, 1'b1);
    check("t5_idle_valid", out_valid, 1'b0);
    drain();

    // T6: reset in WAIT aborts; the stub's late done must be ignored.
    push_poly(-32'sd10, 16'd16);
    send(-32'sd100, 16'd16, 32'd30, n0);
    repeat (33) @(negedge clk);
    rst = 1'b1;
    #1 check_reset("t6");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("t6_no_valid", out_valid, 1'b0);
    end
    check("t6_ready", in_ready, 1'b1);
    push_poly(-32'sd10, 16'd16);
    push_out(32'd510, 16'd32, 1'b0);
    send(-32'sd100, 16'd16, 32'd30, n0);
    drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
